// File: rtl/sfifo_wr_sched_if.sv
// Requester and FIFO write-port bundle for sfifo_wr_sched.
// Ports: s_valid/s_last/s_data/s_len/s_ready per requester,
//        fifo_full/fifo_free status in, fifo_we/fifo_din write out.
interface sfifo_wr_sched_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int LW = 8
);
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_last;
    logic [N*DW-1:0] s_data;
    logic [N*LW-1:0] s_len;
    logic [N-1:0]    s_ready;
    logic            fifo_full;
    logic [AW:0]     fifo_free;
    logic            fifo_we;
    logic [DW-1:0]   fifo_din;

    modport master (
        output s_valid, s_last, s_data, s_len,
        output fifo_full, fifo_free,
        input  s_ready, fifo_we, fifo_din
    );

    modport slave (
        input  s_valid, s_last, s_data, s_len,
        input  fifo_full, fifo_free,
        output s_ready, fifo_we, fifo_din
    );
endinterface

// File: rtl/sfifo_wr_sched.sv
// Packet-atomic round-robin scheduler for one FIFO write port.
// Ports: clk, rst (async, active-low), bus (slave side of
//        sfifo_wr_sched_if), busy, gnt_id, err_len (1-cycle pulse).
module sfifo_wr_sched #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int LW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sfifo_wr_sched_if.slave      bus,
    output logic                 busy,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 err_len
);
    localparam int GW = $clog2(N);
    localparam int CW = (LW > AW + 1) ? LW : AW + 1;
    localparam int KW = LW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [LW-1:0] len_q;
    logic [KW-1:0] cnt;
    logic          err_done;

    logic [N-1:0]  elig;
    logic [N-1:0]  rot;
    logic          found;
    logic [GW-1:0] pick;
    logic [GW:0]   sum;
    logic [LW-1:0] pick_len;

    logic          g_valid;
    logic          g_last;
    logic [DW-1:0] g_data;
    logic [N-1:0]  rdy;
    logic          acc;
    logic [KW:0]   cnt_inc;
    logic [KW:0]   len_x;
    logic          mismatch;

    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
        return (l == '0) ? LW'(1) : l;
    endfunction

    // Space check covers the whole declared packet.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.s_valid[i] &&
                      (CW'(eff_len(bus.s_len[i*LW +: LW])) <=
                       CW'(bus.fifo_free));
        end
    end

    // rot[k] is requester (ptr+k) mod N; lowest k wins.
    always_comb begin
        rot   = N'({elig, elig} >> ptr);
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (GW+1)'(k);
                pick  = (sum >= (GW+1)'(N)) ?
                        GW'(sum - (GW+1)'(N)) : GW'(sum);
            end
        end
    end

    always_comb begin
        pick_len = eff_len(bus.s_len[LW-1:0]);
        for (int i = 0; i < N; i++) begin
            if (pick == GW'(i)) begin
                pick_len = eff_len(bus.s_len[i*LW +: LW]);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = bus.s_data[DW-1:0];
        for (int i = 0; i < N; i++) begin
            if (gnt_id == GW'(i)) begin
                g_valid = bus.s_valid[i];
                g_last  = bus.s_last[i];
                g_data  = bus.s_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        rdy = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = (state == BUSY) && !bus.fifo_full &&
                     (gnt_id == GW'(i));
        end
    end

    assign acc          = (state == BUSY) && g_valid && !bus.fifo_full;
    assign bus.s_ready  = rdy;
    assign bus.fifo_we  = acc;
    assign bus.fifo_din = g_data;

    // Short packet is judged at s_last; overrun as soon as it happens.
    assign cnt_inc  = {1'b0, cnt} + 1'b1;
    assign len_x    = (KW+1)'(len_q);
    assign mismatch = g_last ? (cnt_inc != len_x) : (cnt_inc > len_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gnt_id   <= '0;
            ptr      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            err_len  <= 1'b0;
            err_done <= 1'b0;
        end else begin
            err_len <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= BUSY;
                        busy     <= 1'b1;
                        gnt_id   <= pick;
                        len_q    <= pick_len;
                        cnt      <= '0;
                        err_done <= 1'b0;
                    end
                end
                BUSY: begin
                    if (acc) begin
                        if (!cnt_inc[KW]) begin
                            cnt <= cnt_inc[KW-1:0];
                        end
                        if (mismatch && !err_done) begin
                            err_len  <= 1'b1;
                            err_done <= 1'b1;
                        end
                        if (g_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            ptr   <= (gnt_id == GW'(N - 1)) ?
                                     '0 : gnt_id + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfifo_wr_sched.sv
// Self-checking bench for sfifo_wr_sched: directed table,
// hand-written corner sequences and a randomized model run.
`timescale 1ns/1ps
module tb_sfifo_wr_sched;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int LW  = 8;
    localparam int GW  = 2;
    localparam int CAP = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          busy;
    logic [GW-1:0] gnt_id;
    logic          err_len;

    sfifo_wr_sched_if #(.N(N), .DW(DW), .AW(AW), .LW(LW)) bus ();

    sfifo_wr_sched #(.N(N), .DW(DW), .AW(AW), .LW(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .gnt_id (gnt_id),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Requester packet generators
    int act[N], nb[N], bi[N], ln[N], seq[N];
    bit refill, rnd, vrand;
    int fixlen;

    // FIFO side
    int free_v;
    bit full_v;
    bit fifo_model;
    int fcount;
    bit last_we;
    logic [DW-1:0] wlog[$];

    // Reference model
    int m_busy, m_gnt, m_ptr, m_cnt, m_len, m_err, m_done;

    function automatic logic [DW-1:0] dat(input int i);
        return DW'((i << 6) | ((seq[i] & 7) << 3) | (bi[i] & 7));
    endfunction

    task automatic new_pkt(input int i);
        int e;
        seq[i]++;
        bi[i]  = 0;
        act[i] = 1;
        if (rnd) begin
            ln[i] = $urandom_range(0, 6);
            e     = (ln[i] == 0) ? 1 : ln[i];
            nb[i] = ($urandom_range(0, 4) == 0) ?
                    $urandom_range(1, 7) : e;
        end else begin
            ln[i] = fixlen;
            nb[i] = fixlen;
        end
    endtask

    task automatic set_pkt(input int i, input int l, input int n);
        seq[i]++;
        bi[i]  = 0;
        act[i] = 1;
        ln[i]  = l;
        nb[i]  = n;
    endtask

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_ptr = 0;
        m_cnt = 0; m_len = 0; m_err = 0; m_done = 0;
    endtask

    task automatic drive();
        if (fifo_model) begin
            free_v = CAP - fcount;
            full_v = (fcount >= CAP);
        end
        for (int i = 0; i < N; i++) begin
            bus.s_valid[i] = (act[i] != 0) &&
                             (!vrand || $urandom_range(0, 3) != 0);
            bus.s_last[i]  = (bi[i] == nb[i] - 1);
            bus.s_data[i*DW +: DW] = dat(i);
            bus.s_len[i*LW +: LW]  = LW'(ln[i]);
        end
        bus.fifo_free = (AW+1)'(free_v);
        bus.fifo_full = full_v;
    endtask

    function automatic int exp_rdy();
        if (m_busy != 0 && !bus.fifo_full) return 1 << m_gnt;
        return 0;
    endfunction

    function automatic int exp_we();
        return (m_busy != 0 && !bus.fifo_full &&
                bus.s_valid[m_gnt]) ? 1 : 0;
    endfunction

    task automatic settle();
        @(negedge clk);
        chk("busy", int'(busy), m_busy);
        chk("gnt_id", int'(gnt_id), m_gnt);
        chk("err_len", int'(err_len), m_err);
        chk("s_ready", int'(bus.s_ready), exp_rdy());
        chk("fifo_we", int'(bus.fifo_we), exp_we());
        if (exp_we() != 0) begin
            chk("fifo_din", int'(bus.fifo_din),
                int'(bus.s_data[m_gnt*DW +: DW]));
        end
        if (fifo_model && bus.fifo_we) begin
            chk("room_on_write", int'(fcount < CAP), 1);
        end
        last_we = bus.fifo_we;
        if (bus.fifo_we) wlog.push_back(bus.fifo_din);
    endtask

    task automatic advance();
        bit acc[N];
        bit picked;
        int i, e;
        @(posedge clk);
        for (int r = 0; r < N; r++) begin
            acc[r] = (m_busy != 0) && !bus.fifo_full &&
                     (m_gnt == r) && bus.s_valid[r];
        end
        m_err = 0;
        if (m_busy == 0) begin
            picked = 0;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                e = int'(bus.s_len[i*LW +: LW]);
                if (e == 0) e = 1;
                if (!picked && bus.s_valid[i] &&
                    e <= int'(bus.fifo_free)) begin
                    picked = 1;
                    m_busy = 1; m_gnt = i; m_len = e;
                    m_cnt = 0;  m_done = 0;
                end
            end
        end else if (acc[m_gnt]) begin
            m_cnt++;
            if (bus.s_last[m_gnt]) begin
                if (m_cnt != m_len && m_done == 0) m_err = 1;
                m_busy = 0;
                m_ptr  = (m_gnt + 1) % N;
            end else if (m_cnt > m_len && m_done == 0) begin
                m_err  = 1;
                m_done = 1;
            end
        end
        for (int r = 0; r < N; r++) begin
            if (acc[r]) begin
                if (bus.s_last[r]) begin
                    if (refill) new_pkt(r);
                    else act[r] = 0;
                end else begin
                    bi[r]++;
                end
            end
        end
        if (fifo_model) begin
            if (last_we) fcount++;
            if (fcount > 0 && $urandom_range(0, 2) == 0) fcount--;
        end
        #1;
    endtask

    task automatic cyc();
        drive();
        settle();
        advance();
    endtask

    task automatic clear_gen();
        for (int i = 0; i < N; i++) begin
            act[i] = 0; nb[i] = 0; bi[i] = 0; ln[i] = 0; seq[i] = 0;
        end
        refill = 0; rnd = 0; vrand = 0; fixlen = 1;
        fifo_model = 0; fcount = 0; last_we = 0;
        free_v = 256; full_v = 0;
        wlog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_gen();
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          v;
        bit          last;
        logic [7:0]  d;
        bit          full;
        bit          e_busy;
        bit          e_we;
        logic [7:0]  e_din;
        bit          e_err;
    } vec_t;

    vec_t tv[6];
    int   errs;

    initial begin
        tv[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
        tv[2] = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0};
        tv[3] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0};
        tv[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

        // Outputs stay quiet in reset even with requests pending
        clear_gen();
        model_reset();
        for (int i = 0; i < N; i++) set_pkt(i, 2, 2);
        drive();
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt", int'(gnt_id), 0);
        chk("rst_err", int'(err_len), 0);
        chk("rst_ready", int'(bus.s_ready), 0);
        chk("rst_we", int'(bus.fifo_we), 0);

        // Single requester, 3 beats, table driven
        do_reset();
        for (int r = 0; r < 6; r++) begin
            drive();
            bus.s_valid[0]       = tv[r].v;
            bus.s_last[0]        = tv[r].last;
            bus.s_data[DW-1:0]   = tv[r].d;
            bus.s_len[LW-1:0]    = 8'd3;
            bus.fifo_full        = tv[r].full;
            settle();
            chk("t1_busy", int'(busy), int'(tv[r].e_busy));
            chk("t1_we", int'(bus.fifo_we), int'(tv[r].e_we));
            if (tv[r].e_we) begin
                chk("t1_din", int'(bus.fifo_din), int'(tv[r].e_din));
            end
            chk("t1_err", int'(err_len), int'(tv[r].e_err));
            advance();
        end
        set_pkt(0, 1, 1);
        set_pkt(1, 1, 1);
        cyc();
        drive();
        settle();
        chk("t1_ptr_next", int'(gnt_id), 1);
        advance();
        repeat (4) cyc();

        // Four requesters, len 2, continuous
        do_reset();
        fixlen = 2;
        refill = 1;
        for (int i = 0; i < N; i++) new_pkt(i);
        for (int c = 0; c < 15; c++) begin
            drive();
            settle();
            chk("t2_we_pattern", int'(bus.fifo_we), (c % 3 != 0) ? 1 : 0);
            if (c % 3 == 1) begin
                chk("t2_grant_order", int'(gnt_id), (c / 3) % 4);
            end
            advance();
        end
        chk("t2_nwrites", wlog.size(), 10);
        if (wlog.size() >= 10) begin
            for (int p = 0; p < 5; p++) begin
                for (int b = 0; b < 2; b++) begin
                    chk("t2_stream", int'(wlog[p*2 + b]),
                        ((p % 4) << 6) | ((1 + p / 4) << 3) | b);
                end
            end
        end

        // Space gating: req0 needs 5, req1 needs 2, free 3
        do_reset();
        set_pkt(0, 5, 5);
        set_pkt(1, 2, 2);
        free_v = 3;
        for (int c = 0; c < 14; c++) begin
            if (c >= 6) free_v = 5;
            drive();
            settle();
            if (c == 1) begin
                chk("t3_first_busy", int'(busy), 1);
                chk("t3_first_gnt", int'(gnt_id), 1);
            end
            if (c >= 3 && c <= 6) chk("t3_wait_space", int'(busy), 0);
            if (c == 7) begin
                chk("t3_second_busy", int'(busy), 1);
                chk("t3_second_gnt", int'(gnt_id), 0);
            end
            advance();
        end

        // FIFO full for 4 cycles mid-packet
        do_reset();
        set_pkt(2, 6, 6);
        for (int c = 0; c < 13; c++) begin
            full_v = (c >= 3 && c <= 6);
            drive();
            settle();
            if (full_v) begin
                chk("t4_stall_we", int'(bus.fifo_we), 0);
                chk("t4_stall_ready", int'(bus.s_ready), 0);
            end
            advance();
        end
        chk("t4_nwrites", wlog.size(), 6);
        if (wlog.size() == 6) begin
            for (int b = 0; b < 6; b++) begin
                chk("t4_order", int'(wlog[b]), (2 << 6) | (1 << 3) | b);
            end
        end

        // Short packet: len 4, last on beat 2
        do_reset();
        set_pkt(0, 4, 2);
        errs = 0;
        for (int c = 0; c < 7; c++) begin
            drive();
            settle();
            if (err_len) errs++;
            if (c == 3) begin
                chk("t5a_err_at", int'(err_len), 1);
                chk("t5a_idle", int'(busy), 0);
            end
            advance();
        end
        chk("t5a_pulses", errs, 1);

        // Long packet: len 2, last on beat 4
        do_reset();
        set_pkt(0, 2, 4);
        errs = 0;
        for (int c = 0; c < 9; c++) begin
            drive();
            settle();
            if (err_len) errs++;
            if (c == 4) chk("t5b_err_at", int'(err_len), 1);
            advance();
        end
        chk("t5b_pulses", errs, 1);

        // Async reset in beat 2 of a 4-beat packet
        do_reset();
        set_pkt(0, 1, 1);
        repeat (3) cyc();
        set_pkt(1, 4, 4);
        repeat (2) cyc();
        drive();
        settle();
        chk("t6_pre_busy", int'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ready", int'(bus.s_ready), 0);
        chk("t6_rst_we", int'(bus.fifo_we), 0);
        clear_gen();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_pkt(0, 1, 1);
        set_pkt(1, 1, 1);
        cyc();
        drive();
        settle();
        chk("t6_ptr_restart", int'(gnt_id), 0);
        advance();
        repeat (4) cyc();

        // Randomized traffic against the model, small virtual FIFO
        do_reset();
        rnd = 1;
        refill = 1;
        vrand = 1;
        fifo_model = 1;
        for (int i = 0; i < N; i++) new_pkt(i);
        repeat (3000) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sfifo_wr_sched.md
Name: sfifo_wr_sched

Overview:
- Packet-atomic, round-robin write scheduler that shares the single write port of a synchronous FIFO among N requesters.
- A requester is granted only when the FIFO has room for its whole declared packet, so packets never interleave in the FIFO and never stall on full mid-packet.
- Sits directly in front of the FIFO write port: drives its write enable and write data, and consumes its full and free-space status.

Parameters:
N, 4, number of requesters (2..8)
DW, 8, data width per beat
AW, 8, FIFO address width; FIFO depth is 2^AW
LW, 8, width of the declared packet-length field

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_valid  in  N  per-requester beat valid
s_last  in  N  per-requester last beat of packet
s_data  in  N*DW  per-requester data, requester i at [i*DW +: DW]
s_len  in  N*LW  per-requester declared packet length in beats, sampled at grant; 0 treated as 1
s_ready  out  N  per-requester beat accepted when s_valid&s_ready
fifo_full  in  1  FIFO full flag
fifo_free  in  AW+1  FIFO free entries (0..2^AW)
fifo_we  out  1  FIFO write enable
fifo_din  out  DW  FIFO write data
busy  out  1  a packet is in progress
gnt_id  out  $clog2(N)  current/last granted requester
err_len  out  1  one-cycle pulse on a packet-length mismatch

Behaviour:
- Reset (rst low, async): state=IDLE, busy=0, gnt_id=0, rr pointer=0, beat count=0, err_len=0. s_ready=0 and fifo_we=0 combinationally while in IDLE.
- Eligibility: requester i is eligible iff s_valid[i] && eff_len(i) <= fifo_free. eff_len = (s_len==0) ? 1 : s_len, zero-extended to AW+1 bits.
- IDLE:
  - Select the first eligible requester scanning i = ptr, ptr+1, …, modulo N.
  - If one is found: register gnt_id=i, latch len_q=eff_len, clear cnt, set busy, go to BUSY next cycle.
  - If none is eligible: stay in IDLE. No starvation of ineligible-by-size requests is guaranteed; a large packet waits until space frees.
- BUSY:
  - s_ready[gnt_id] = ~fifo_full; all other s_ready = 0.
  - fifo_we = s_valid[gnt_id] & ~fifo_full; fifo_din = s_data[gnt_id] (mux, combinational).
  - Each accepted beat increments cnt (LW+1 bits, saturating).
  - On an accepted beat with s_last[gnt_id]=1: go to IDLE next cycle, set ptr = gnt_id+1 mod N, clear busy.
- Arbitration timing: one arbitration cycle (IDLE) between consecutive packets; first beat of a grant is accepted no earlier than one cycle after the request is seen eligible.
- Packet boundary is s_last only; len is advisory for space reservation.
- err_len pulses on the cycle after:
  - an accepted beat where (cnt+1 != len_q) with s_last=1, or
  - an accepted beat with cnt+1 > len_q and s_last=0 (fires once per packet).
  - The packet continues to s_last regardless.
- fifo_full asserted in BUSY: stall with no write and no ready; state is held. Never write when fifo_full=1.
- s_valid of the granted requester dropping mid-packet: hold the grant; bubbles allowed.
- s_len / s_valid of other requesters during BUSY: ignored.
- gnt_id holds its value after the packet until the next grant.
- Async reset mid-packet: abort immediately to IDLE. The partial packet already written to the FIFO is not removed; recovery is the system's responsibility.

Test Plan:
- Single requester 0, len=3, 3 beats A1,A2,A3 with last on the 3rd, fifo_free=256 -> busy rises 1 cycle after valid; fifo_we on 3 consecutive cycles writes A1,A2,A3; err_len=0; busy falls; ptr=1.
- All 4 requesters valid with len=2 continuously -> grant order 0,1,2,3,0; each packet is 2 writes followed by exactly 1 idle cycle; no interleaving in the FIFO write sequence.
- fifo_free=3, req0 len=5, req1 len=2, ptr=0 -> req1 granted first; req0 is granted only once fifo_free>=5.
- fifo_full asserted for 4 cycles mid-packet -> fifo_we=0 and s_ready=0 for those 4 cycles; remaining beats are written in order afterwards; no beat lost or duplicated.
- len=4 with last on beat 2 -> err_len pulses once, return to IDLE. Separately, len=2 with last on beat 4 -> exactly one err_len pulse, on the cycle after beat 3.
- rst low during beat 2 of a 4-beat packet -> busy=0, s_ready=0, fifo_we=0 immediately. After release, arbitration restarts from ptr=0.
